// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detectors: valid/ready word intake, one bit per clock out.
// Build option SER_PARITY_EN appends an even-parity bit after each word.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no word in flight, bit_o at IDLE_BIT, ready for a word
// ST_SHIFT | shifting data bits, cnt_q = index of the bit on bit_o
// ST_PARITY| parity slot after the last data bit (SER_PARITY_EN only)
module seq_bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_vld_i,
   output logic             data_rdy_o,
   output logic             bit_o,
   output logic             bit_vld_o,
   output logic             sof_o,
   output logic             busy_o
);

   localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
`ifdef SER_PARITY_EN
      ,ST_PARITY = 2'd2
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   shreg_q, shreg_d;
`ifdef SER_PARITY_EN
   logic               par_q, par_d;
`endif
   logic               head_bit;
   logic               last_slot;
   logic               xfer;

   assign head_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign last_slot = (cnt_q == CNT_LAST);
   assign xfer      = data_vld_i && data_rdy_o;

   // Output decode depends on registered state only, so ready never follows valid.
   always_comb begin
      data_rdy_o = 1'b0;
      bit_o      = IDLE_BIT;
      bit_vld_o  = 1'b0;
      sof_o      = 1'b0;
      busy_o     = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            data_rdy_o = 1'b1;
         end
         ST_SHIFT: begin
            bit_o     = head_bit;
            bit_vld_o = 1'b1;
            sof_o     = (cnt_q == '0);
`ifndef SER_PARITY_EN
            data_rdy_o = last_slot;
`endif
         end
`ifdef SER_PARITY_EN
         ST_PARITY: begin
            bit_o      = par_q;
            bit_vld_o  = 1'b1;
            data_rdy_o = 1'b1;
         end
`endif
         default: begin
            data_rdy_o = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
`ifdef SER_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_SHIFT: begin
            cnt_d   = cnt_q + CNT_W'(1);
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
`ifdef SER_PARITY_EN
            par_d   = par_q ^ head_bit;
`endif
            if (last_slot) begin
               cnt_d = '0;
`ifdef SER_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef SER_PARITY_EN
         ST_PARITY: begin
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A transfer overrides the natural successor so words stream without a gap.
      if (xfer) begin
         state_d = ST_SHIFT;
         cnt_d   = '0;
         shreg_d = data_i;
`ifdef SER_PARITY_EN
         par_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
`ifdef SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
`ifdef SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule
